multi_in_one_out_fifo_lib: RTL
==============================

# multi_in_one_out_fifo_lib

Parametrised circular FIFO accepting up to IN_NUM entries per cycle and delivering one entry per cycle. It is the next generation of the library single-lane FIFO and sits between multi-issue producers (e.g. dual-lane result writeback) and single-consumer pipelines. It adds a selectable mode: full backpressure or overwrite-oldest. It also adds occupancy, almost-full and overflow reporting.

## Interface
- ENT_NUM, 8, entry count; any integer ≥ 2 and ≥ IN_NUM, not required to be a power of two
- DATA_SIZE, 32, bits per entry
- IN_NUM, 2, input lanes, ≥ 1
- OVERWRITE, 0, 0 = backpressure mode, 1 = overwrite-oldest mode
- AFULL_THR, ENT_NUM-IN_NUM, fifo_afull asserts when ent_cnt ≥ AFULL_THR
- PTR_W / CNT_W, derived: $clog2(ENT_NUM) / $clog2(ENT_NUM+1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_vld  in  IN_NUM  per-lane write request; lanes may be sparse
- in_data  in  IN_NUM*DATA_SIZE  lane k at bits [k*DATA_SIZE +: DATA_SIZE]
- in_rdy  out  1  all-or-nothing accept for every valid lane this cycle
- out_vld  out  1  head entry valid
- out_data  out  DATA_SIZE  head entry data
- pick_rdy  in  1  consumer takes head when out_vld=1
- fifo_full  out  1  ent_cnt == ENT_NUM
- fifo_afull  out  1  ent_cnt ≥ AFULL_THR
- fifo_empty  out  1  ent_cnt == 0
- ent_cnt  out  CNT_W  current occupancy
- ovf_pulse  out  1  overwrite mode only: one-cycle pulse, one cycle after a write discarded ≥1 entry

## Operation
- push_n = popcount(in_vld) when in_rdy, else 0. pop = out_vld & pick_rdy.
- Lane compaction: the j-th set lane, counted from lane 0, is written to slot (wr_ptr + j) mod ENT_NUM. wr_ptr advances by push_n mod ENT_NUM.
- Backpressure mode: in_rdy = (ENT_NUM − ent_cnt) ≥ IN_NUM, evaluated on the registered count. A same-cycle pop is not credited. Unaccepted lanes are not written. The producer holds its request.
- Overwrite mode: in_rdy is constant 1. excess = max(0, ent_cnt + push_n − pop − ENT_NUM).
  - rd_ptr advances by pop + excess; ent_cnt saturates at ENT_NUM.
  - The discarded entries are always the oldest. The newest written data is never dropped.
  - ovf_pulse is registered high for one cycle when excess > 0.
- ent_cnt_nxt = ent_cnt + push_n − pop − excess.
- Pop with out_vld=0 is ignored; rd_ptr and ent_cnt are unchanged.
- out_data = storage[rd_ptr], muxed combinationally from registered storage. Its value is don't-care while out_vld=0.
- Pointer wrap uses explicit compare-and-subtract modulo ENT_NUM, so non-power-of-two depths are legal.

## Timing
- Reset (async assert, sync-to-clk deassert by the system):
  - wr_ptr=0, rd_ptr=0, ent_cnt=0, ovf_pulse=0
  - out_vld=0, fifo_empty=1, fifo_full=0, fifo_afull=(AFULL_THR==0)
  - in_rdy=1
- Storage is not reset.
- Write-to-read latency is 1 cycle: data pushed at edge N is on out_data with out_vld=1 after edge N. There is no bypass.
- Simultaneous push and pop on a non-empty FIFO: head pops, new data lands at the tail, and the count changes by push_n − 1.
- Reset mid-operation empties the FIFO immediately. Data in flight is lost; no pulse is generated.
- All status outputs are derived from registered state. ovf_pulse is a pure register.

## Structure
- Uses library flops DFFRE for control and DFFE for data. Storage write enables are one-hot per entry.
- Shared library header holds the ceil-log2 width derivation macros and the OVERWRITE mode encodings (FIFO_MODE_BP=0, FIFO_MODE_OVW=1).
- Sub-module lane_compact_lib (IN_NUM parameter) produces per-lane prefix-popcount offsets and total push_n. It is reused by future multi-in buffers.

## Test plan
- Reset then idle: out_vld=0, fifo_empty=1, in_rdy=1, ent_cnt=0. Assert rst_n low mid-traffic with 5 entries: all status returns to reset values asynchronously.
- ENT_NUM=8, IN_NUM=2, BP mode: push pairs A0..A7 over 4 cycles with no pop → ent_cnt=8, fifo_full=1, in_rdy=0. A further push is refused. Popping returns A0..A7 in order.
- Sparse lanes: in_vld=2'b10 with data B, next cycle 2'b11 with C0,C1 → output order B, C0, C1.
- Wrap with ENT_NUM=6: 20 cycles of push 1 / pop 1 → output order matches input order; pointers wrap 5→0; ent_cnt stays at 1.
- Overwrite mode, ENT_NUM=4: fill D0..D3, then push E0,E1 without pop → ent_cnt=4, head=D2, ovf_pulse=1 for exactly one cycle on the following cycle. Output order is D2, D3, E0, E1.
- Full with simultaneous pop in overwrite mode: push 2, pop 1 at ent_cnt=4 → excess=1, one oldest entry dropped plus one popped, ent_cnt=4.

Source files
------------

// File: rtl/multi_in_one_out_fifo_lib_pkg.sv
// Shared definitions for the multi-in / one-out FIFO library:
// mode encodings and the modulo pointer helper.
package multi_in_one_out_fifo_lib_pkg;

  localparam int FIFO_MODE_BP  = 0;
  localparam int FIFO_MODE_OVW = 1;

  // Compare-and-subtract wrap; both operands are below n, so one subtract suffices.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/multi_in_one_out_fifo_lib_lane_compact.sv
// Per-lane prefix popcount of the valid lanes plus the total count.
// Lane k lands at offset = number of valid lanes below k.
module lane_compact_lib #(
  parameter  int IN_NUM = 2,
  localparam int OFS_W  = $clog2(IN_NUM + 1)
) (
  input  logic [IN_NUM-1:0]            in_vld,
  output logic [IN_NUM-1:0][OFS_W-1:0] lane_ofs,
  output logic [OFS_W-1:0]             vld_cnt
);

  logic [OFS_W-1:0] acc;

  always_comb begin
    acc      = '0;
    lane_ofs = '0;
    for (int k = 0; k < IN_NUM; k++) begin
      lane_ofs[k] = acc;
      acc         = acc + OFS_W'(in_vld[k]);
    end
    vld_cnt = acc;
  end

endmodule

// File: rtl/multi_in_one_out_fifo_lib.sv
// Circular FIFO taking up to IN_NUM sparse lanes per cycle, draining one per cycle,
// with backpressure or overwrite-oldest behaviour when full.
module multi_in_one_out_fifo_lib
  import multi_in_one_out_fifo_lib_pkg::*;
#(
  parameter  int ENT_NUM   = 8,
  parameter  int DATA_SIZE = 32,
  parameter  int IN_NUM    = 2,
  parameter  int OVERWRITE = FIFO_MODE_BP,
  parameter  int AFULL_THR = ENT_NUM - IN_NUM,
  localparam int PTR_W     = $clog2(ENT_NUM),
  localparam int CNT_W     = $clog2(ENT_NUM + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [IN_NUM-1:0]           in_vld,
  input  logic [IN_NUM*DATA_SIZE-1:0] in_data,
  output logic                        in_rdy,
  output logic                        out_vld,
  output logic [DATA_SIZE-1:0]        out_data,
  input  logic                        pick_rdy,
  output logic                        fifo_full,
  output logic                        fifo_afull,
  output logic                        fifo_empty,
  output logic [CNT_W-1:0]            ent_cnt,
  output logic                        ovf_pulse
);

  localparam int OFS_W = $clog2(IN_NUM + 1);

  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [DATA_SIZE-1:0] mem [ENT_NUM];

  logic [IN_NUM-1:0][OFS_W-1:0] lane_ofs;
  logic [IN_NUM-1:0][PTR_W-1:0] lane_slot;
  logic [OFS_W-1:0]             vld_cnt, push_n;
  logic                         pop;
  int                           grow, excess;

  logic [ENT_NUM-1:0]                ent_we;
  logic [ENT_NUM-1:0][DATA_SIZE-1:0] ent_wdata;

  lane_compact_lib #(.IN_NUM(IN_NUM)) u_compact (
    .in_vld   (in_vld),
    .lane_ofs (lane_ofs),
    .vld_cnt  (vld_cnt)
  );

  // Credit is taken from the registered count only; a same-cycle pop does not help.
  assign in_rdy     = (OVERWRITE == FIFO_MODE_OVW) || ((ENT_NUM - int'(ent_cnt)) >= IN_NUM);
  assign out_vld    = (ent_cnt != '0);
  assign fifo_empty = (ent_cnt == '0);
  assign fifo_full  = (int'(ent_cnt) == ENT_NUM);
  assign fifo_afull = (int'(ent_cnt) >= AFULL_THR);
  assign out_data   = mem[rd_ptr];

  assign push_n = in_rdy ? vld_cnt : '0;
  assign pop    = out_vld & pick_rdy;

  always_comb begin
    lane_slot = '0;
    for (int k = 0; k < IN_NUM; k++)
      lane_slot[k] = PTR_W'(wrap_add(int'(wr_ptr), int'(lane_ofs[k]), ENT_NUM));
  end

  // Excess entries are the oldest ones; skipping rd_ptr past them discards them.
  always_comb begin
    grow   = int'(ent_cnt) + int'(push_n) - int'(pop);
    excess = 0;
    if (OVERWRITE == FIFO_MODE_OVW && grow > ENT_NUM)
      excess = grow - ENT_NUM;
    cnt_nxt = CNT_W'(grow - excess);
    rd_nxt  = PTR_W'(wrap_add(int'(rd_ptr), int'(pop) + excess, ENT_NUM));
    wr_nxt  = PTR_W'(wrap_add(int'(wr_ptr), int'(push_n), ENT_NUM));
  end

  always_comb begin
    ent_we    = '0;
    ent_wdata = '0;
    for (int e = 0; e < ENT_NUM; e++)
      for (int k = 0; k < IN_NUM; k++)
        if (in_rdy && in_vld[k] && int'(lane_slot[k]) == e) begin
          ent_we[e]    = 1'b1;
          ent_wdata[e] = in_data[k*DATA_SIZE +: DATA_SIZE];
        end
  end

  always_ff @(posedge clk)
    for (int e = 0; e < ENT_NUM; e++)
      if (ent_we[e]) mem[e] <= ent_wdata[e];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ent_cnt   <= '0;
      ovf_pulse <= 1'b0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      ent_cnt   <= cnt_nxt;
      ovf_pulse <= (excess > 0);
    end
  end

endmodule
